// File: rtl/core_run_ctrl.sv
// Board run controller: holds the core in reset until clock lock, counts run cycles,
// captures the tohost verdict or a timeout, then pages result/cycle count to the display.
module core_run_ctrl #(
  parameter int HOLD_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 100_000_000,
  parameter int DISP_PERIOD    = 50_000_000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        locked,
  input  logic [31:0] tohost,
  output logic        core_rst,
  output logic [31:0] disp,
  output logic        disp_sel,
  output logic [1:0]  status,
  output logic        done
);

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_HOLD      = 3'd1,
    ST_RUN       = 3'd2,
    ST_PASS      = 3'd3,
    ST_FAIL      = 3'd4,
    ST_TIMEOUT   = 3'd5
  } state_t;

  localparam logic [31:0] HOLD_LAST    = 32'(HOLD_CYCLES - 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] DISP_LAST    = 32'(DISP_PERIOD - 1);

  logic [1:0]  sync_r;
  logic        lk_s;
  state_t      state_r, state_s;
  logic [31:0] hold_r, hold_s;
  logic [31:0] cyc_r, cyc_s;
  logic [31:0] result_r, result_s;
  logic [31:0] page_r, page_s;
  logic        sel_s;
  logic        core_rst_s;
  logic [1:0]  status_s;
  logic        done_s;
  logic [31:0] disp_s;

  assign lk_s = sync_r[1];

  // Two-flop synchronizer for the asynchronous lock input
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_r <= 2'b00;
    end else begin
      sync_r <= {sync_r[0], locked};
    end
  end

  // Next-state, counter, capture and display-page logic
  always_comb begin
    state_s  = state_r;
    hold_s   = hold_r;
    cyc_s    = cyc_r;
    result_s = result_r;
    page_s   = page_r;
    sel_s    = disp_sel;
    if (!lk_s && (state_r != ST_WAIT_LOCK)) begin
      state_s  = ST_WAIT_LOCK;
      cyc_s    = 32'd0;
      result_s = 32'd0;
      page_s   = 32'd0;
      sel_s    = 1'b0;
    end else begin
      case (state_r)
        ST_WAIT_LOCK: begin
          if (lk_s) begin
            state_s = ST_HOLD;
            hold_s  = 32'd0;
          end else begin
            state_s = ST_WAIT_LOCK;
          end
        end
        ST_HOLD: begin
          if (hold_r == HOLD_LAST) begin
            state_s = ST_RUN;
            cyc_s   = 32'd0;
          end else begin
            hold_s = hold_r + 32'd1;
          end
        end
        ST_RUN: begin
          // A verdict takes priority over a coincident timeout; cyc freezes on exit
          if (tohost == 32'd1) begin
            state_s  = ST_PASS;
            result_s = tohost;
            page_s   = 32'd0;
            sel_s    = 1'b1;
          end else if (tohost != 32'd0) begin
            state_s  = ST_FAIL;
            result_s = tohost;
            page_s   = 32'd0;
            sel_s    = 1'b1;
          end else if (cyc_r == TIMEOUT_LAST) begin
            state_s  = ST_TIMEOUT;
            result_s = 32'hFFFF_FFFF;
            page_s   = 32'd0;
            sel_s    = 1'b1;
          end else if (cyc_r != 32'hFFFF_FFFF) begin
            cyc_s = cyc_r + 32'd1;
          end else begin
            cyc_s = cyc_r;
          end
        end
        ST_PASS, ST_FAIL, ST_TIMEOUT: begin
          if (page_r == DISP_LAST) begin
            page_s = 32'd0;
            sel_s  = ~disp_sel;
          end else begin
            page_s = page_r + 32'd1;
          end
        end
        default: begin
          state_s = ST_WAIT_LOCK;
        end
      endcase
    end
  end

  // Output values computed from the next state so the outputs can be registered
  always_comb begin
    core_rst_s = (state_s != ST_RUN);
    done_s     = 1'b0;
    status_s   = 2'b00;
    disp_s     = sel_s ? result_s : cyc_s;
    case (state_s)
      ST_WAIT_LOCK, ST_HOLD: status_s = 2'b00;
      ST_RUN:                status_s = 2'b01;
      ST_PASS: begin
        status_s = 2'b10;
        done_s   = 1'b1;
      end
      ST_FAIL, ST_TIMEOUT: begin
        status_s = 2'b11;
        done_s   = 1'b1;
      end
      default: status_s = 2'b00;
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r  <= ST_WAIT_LOCK;
      hold_r   <= 32'd0;
      cyc_r    <= 32'd0;
      result_r <= 32'd0;
      page_r   <= 32'd0;
      disp_sel <= 1'b0;
      core_rst <= 1'b1;
      status   <= 2'b00;
      done     <= 1'b0;
      disp     <= 32'd0;
    end else begin
      state_r  <= state_s;
      hold_r   <= hold_s;
      cyc_r    <= cyc_s;
      result_r <= result_s;
      page_r   <= page_s;
      disp_sel <= sel_s;
      core_rst <= core_rst_s;
      status   <= status_s;
      done     <= done_s;
      disp     <= disp_s;
    end
  end

endmodule

// File: tb/tb_core_run_ctrl.sv
// Directed bench for core_run_ctrl: lock/hold sequencing, pass/fail/timeout verdicts,
// display paging, loss of lock and asynchronous reset.
module tb_core_run_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        locked, locked_to;
  logic [31:0] tohost, tohost_to;
  logic        core_rst, core_rst_to;
  logic [31:0] disp, disp_to;
  logic        disp_sel, disp_sel_to;
  logic [1:0]  status, status_to;
  logic        done, done_to;

  int checks = 0;
  int errors = 0;

  core_run_ctrl #(.HOLD_CYCLES(16), .TIMEOUT_CYCLES(100_000_000), .DISP_PERIOD(8)) dut (
    .CLK(CLK), .RST(RST), .locked(locked), .tohost(tohost), .core_rst(core_rst),
    .disp(disp), .disp_sel(disp_sel), .status(status), .done(done));

  core_run_ctrl #(.HOLD_CYCLES(16), .TIMEOUT_CYCLES(64), .DISP_PERIOD(8)) dut_to (
    .CLK(CLK), .RST(RST), .locked(locked_to), .tohost(tohost_to), .core_rst(core_rst_to),
    .disp(disp_to), .disp_sel(disp_sel_to), .status(status_to), .done(done_to));

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b0; locked = 1'b0; locked_to = 1'b0; tohost = 32'd0; tohost_to = 32'd0;
    repeat (2) tick();
    checks++; if (core_rst !== 1'b1) begin errors++; $display("FAIL reset_core_rst got %0b exp 1", core_rst); end
    checks++; if (disp !== 32'd0) begin errors++; $display("FAIL reset_disp got %0h exp 0", disp); end
    checks++; if (disp_sel !== 1'b0) begin errors++; $display("FAIL reset_sel got %0b exp 0", disp_sel); end
    checks++; if (status !== 2'b00) begin errors++; $display("FAIL reset_status got %0b exp 00", status); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b exp 0", done); end
    RST = 1'b1;
  endtask

  task automatic test_lock_seq();
    locked = 1'b1;
    for (int k = 1; k <= 19; k++) begin
      tick();
      checks++;
      if (core_rst !== ((k < 19) ? 1'b1 : 1'b0)) begin
        errors++; $display("FAIL hold_core_rst edge %0d got %0b", k, core_rst);
      end
      checks++;
      if (status !== ((k < 19) ? 2'b00 : 2'b01)) begin
        errors++; $display("FAIL hold_status edge %0d got %0b", k, status);
      end
    end
    checks++; if (disp !== 32'd0) begin errors++; $display("FAIL run_first_disp got %0d exp 0", disp); end
    for (int k = 1; k <= 5; k++) begin
      tick();
      checks++; if (disp !== 32'(k)) begin errors++; $display("FAIL run_count got %0d exp %0d", disp, k); end
    end
    repeat (495) tick();
    checks++; if (disp !== 32'd500) begin errors++; $display("FAIL run_500 got %0d exp 500", disp); end
  endtask

  task automatic test_pass();
    tohost = 32'd1;
    tick();
    tohost = 32'd0;
    checks++; if (status !== 2'b10) begin errors++; $display("FAIL pass_status got %0b exp 10", status); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL pass_done got %0b exp 1", done); end
    checks++; if (core_rst !== 1'b1) begin errors++; $display("FAIL pass_core_rst got %0b exp 1", core_rst); end
    checks++; if (disp !== 32'd1 || disp_sel !== 1'b1) begin
      errors++; $display("FAIL pass_disp got %0h/%0b exp 1/1", disp, disp_sel); end
    for (int i = 1; i <= 16; i++) begin
      tick();
      checks++;
      if ((i / 8) % 2 == 0) begin
        if (disp !== 32'd1 || disp_sel !== 1'b1) begin
          errors++; $display("FAIL pass_page i=%0d got %0h/%0b exp 1/1", i, disp, disp_sel); end
      end else begin
        if (disp !== 32'd500 || disp_sel !== 1'b0) begin
          errors++; $display("FAIL pass_page i=%0d got %0h/%0b exp 500/0", i, disp, disp_sel); end
      end
    end
  endtask

  task automatic test_async_reset();
    #2;
    RST = 1'b0;
    #1;
    checks++; if (core_rst !== 1'b1 || status !== 2'b00 || done !== 1'b0 || disp !== 32'd0 || disp_sel !== 1'b0) begin
      errors++; $display("FAIL async_reset got rst=%0b st=%0b done=%0b disp=%0h sel=%0b",
                         core_rst, status, done, disp, disp_sel); end
    tick();
    RST = 1'b1;
  endtask

  task automatic test_fail();
    repeat (19) tick();
    checks++; if (status !== 2'b01 || disp !== 32'd0) begin
      errors++; $display("FAIL fail_relock got st=%0b disp=%0h exp 01/0", status, disp); end
    repeat (20) tick();
    tohost = 32'd7;
    tick();
    tohost = 32'd0;
    checks++; if (status !== 2'b11 || done !== 1'b1 || core_rst !== 1'b1) begin
      errors++; $display("FAIL fail_status got st=%0b done=%0b rst=%0b", status, done, core_rst); end
    checks++; if (disp !== 32'd7 || disp_sel !== 1'b1) begin
      errors++; $display("FAIL fail_result got %0h/%0b exp 7/1", disp, disp_sel); end
    repeat (8) tick();
    checks++; if (disp !== 32'd20 || disp_sel !== 1'b0) begin
      errors++; $display("FAIL fail_cyc got %0d/%0b exp 20/0", disp, disp_sel); end
    repeat (8) tick();
    checks++; if (disp !== 32'd7 || disp_sel !== 1'b1) begin
      errors++; $display("FAIL fail_back got %0h/%0b exp 7/1", disp, disp_sel); end
    RST = 1'b0;
    tick();
    RST = 1'b1;
  endtask

  task automatic test_lock_loss();
    repeat (19) tick();
    repeat (10) tick();
    locked = 1'b0;
    repeat (2) tick();
    checks++; if (status !== 2'b01 || core_rst !== 1'b0) begin
      errors++; $display("FAIL loss_early got st=%0b rst=%0b exp 01/0", status, core_rst); end
    tick();
    checks++; if (core_rst !== 1'b1 || status !== 2'b00 || disp !== 32'd0 || done !== 1'b0 || disp_sel !== 1'b0) begin
      errors++; $display("FAIL loss got rst=%0b st=%0b disp=%0h", core_rst, status, disp); end
    locked = 1'b1;
    repeat (18) tick();
    checks++; if (core_rst !== 1'b1) begin errors++; $display("FAIL relock_hold got %0b exp 1", core_rst); end
    tick();
    checks++; if (core_rst !== 1'b0 || status !== 2'b01 || disp !== 32'd0) begin
      errors++; $display("FAIL relock_run got rst=%0b st=%0b disp=%0h", core_rst, status, disp); end
    repeat (5) tick();
    checks++; if (disp !== 32'd5) begin errors++; $display("FAIL relock_count got %0d exp 5", disp); end
  endtask

  task automatic test_timeout();
    locked_to = 1'b1;
    repeat (19) tick();
    checks++; if (status_to !== 2'b01) begin errors++; $display("FAIL to_run got %0b exp 01", status_to); end
    repeat (63) tick();
    checks++; if (status_to !== 2'b01 || disp_to !== 32'd63) begin
      errors++; $display("FAIL to_before got st=%0b disp=%0d exp 01/63", status_to, disp_to); end
    tick();
    checks++; if (status_to !== 2'b11 || done_to !== 1'b1 || core_rst_to !== 1'b1) begin
      errors++; $display("FAIL to_status got st=%0b done=%0b", status_to, done_to); end
    checks++; if (disp_to !== 32'hFFFF_FFFF || disp_sel_to !== 1'b1) begin
      errors++; $display("FAIL to_result got %0h/%0b exp ffffffff/1", disp_to, disp_sel_to); end
    repeat (8) tick();
    checks++; if (disp_to !== 32'd63 || disp_sel_to !== 1'b0) begin
      errors++; $display("FAIL to_cyc got %0d/%0b exp 63/0", disp_to, disp_sel_to); end
  endtask

  task automatic test_verdict_tie();
    locked_to = 1'b0;
    repeat (3) tick();
    checks++; if (status_to !== 2'b00 || core_rst_to !== 1'b1 || disp_to !== 32'd0) begin
      errors++; $display("FAIL tie_unlock got st=%0b rst=%0b disp=%0h", status_to, core_rst_to, disp_to); end
    locked_to = 1'b1;
    repeat (19) tick();
    repeat (63) tick();
    tohost_to = 32'd1;
    tick();
    tohost_to = 32'd0;
    checks++; if (status_to !== 2'b10 || disp_to !== 32'd1) begin
      errors++; $display("FAIL tie_pass got st=%0b disp=%0h exp 10/1", status_to, disp_to); end
    repeat (8) tick();
    checks++; if (disp_to !== 32'd63) begin errors++; $display("FAIL tie_cyc got %0d exp 63", disp_to); end
  endtask

  initial begin
    test_reset();
    test_lock_seq();
    test_pass();
    test_async_reset();
    test_fail();
    test_lock_loss();
    test_timeout();
    test_verdict_tie();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_run_ctrl.md
# core_run_ctrl

Run controller that sequences the processor core on the FPGA board. It holds the core in reset until the clock wizard reports lock, then releases it and counts execution cycles. It watches the core's `tohost` word for a test verdict or a timeout, then freezes the core. It drives the 32-bit word shown on the seven-segment driver, alternating between the captured result and the cycle count once the run ends. It sits in the board top between the clock wizard, `top` and `SEG_PUT`.

## Interface
Parameters:
- `HOLD_CYCLES`, default 16: cycles the core reset stays asserted after lock before release (≥1).
- `TIMEOUT_CYCLES`, default 100_000_000: run-cycle limit; reaching it ends the run as timeout.
- `DISP_PERIOD`, default 50_000_000: cycles each display page is shown after the run ends (≥1).

Ports:
- `CLK` in 1: single clock, the clock-wizard output driving the core.
- `RST` in 1: asynchronous, active-low reset for this block.
- `locked` in 1: clock-wizard lock, asynchronous to `CLK`, synchronized internally.
- `tohost` in 32: core result word; 0 = running, 1 = pass, other = fail.
- `core_rst` out 1: active-high reset to the core `RST`.
- `disp` out 32: word to `SEG_PUT` `check`.
- `disp_sel` out 1: 0 = `disp` shows the cycle count, 1 = `disp` shows the result word.
- `status` out 2: 00 = not running, 01 = running, 10 = pass, 11 = fail or timeout.
- `done` out 1: high in every terminal state.

## Operation
- `locked` passes through a 2-flop synchronizer; `lk` is the synchronized value.
- States:
  - WAIT_LOCK: `core_rst`=1; when `lk`=1 go to HOLD with `hold_cnt` cleared.
  - HOLD: `core_rst`=1; `hold_cnt` increments each cycle; when `hold_cnt`=HOLD_CYCLES-1 go to RUN with `cyc` cleared.
  - RUN: `core_rst`=0; `cyc` increments by 1 each cycle.
    - `tohost`==1 → PASS.
    - `tohost`≠0 and ≠1 → FAIL.
    - else if `cyc`==TIMEOUT_CYCLES-1 → TIMEOUT.
    - On entry to PASS or FAIL, the `tohost` value is latched into `result`. On entry to TIMEOUT, `result` gets 0xFFFF_FFFF.
  - PASS, FAIL, TIMEOUT: terminal; `core_rst`=1 (core frozen); `cyc` holds.
- A verdict and the timeout in the same RUN cycle: the verdict wins.
- `lk`=0 in any state except WAIT_LOCK → WAIT_LOCK next cycle. `cyc`, `result`, `disp_sel` and the page counter are cleared.
- Leaving a terminal state requires the `RST` reset or a loss of lock.
- `cyc` is 32 bits and saturates at 0xFFFF_FFFF (it cannot wrap before timeout with the default).
- Display:
  - In WAIT_LOCK, HOLD and RUN: `disp_sel`=0 and `disp`=`cyc`.
  - In terminal states, a page counter counts 0..DISP_PERIOD-1. At wrap, `disp_sel` toggles, starting at 1 on terminal entry.
  - `disp` = `disp_sel` ? `result` : `cyc`.
- `status`: WAIT_LOCK/HOLD=00, RUN=01, PASS=10, FAIL/TIMEOUT=11.

## Timing
- All outputs are registered, with no combinational path from inputs to outputs.
- Reset (`RST`=0): state WAIT_LOCK, `core_rst`=1, `disp`=0, `disp_sel`=0, `status`=00, `done`=0. `result`, `cyc`, `hold_cnt`, page counter and synchronizer flops are all 0.
- `locked` rising at edge n gives `lk`=1 after edge n+2. HOLD is entered on the next edge.
- `core_rst` is high for exactly HOLD_CYCLES cycles in HOLD. It falls on the same edge that enters RUN.
- In the first RUN cycle `cyc`=0.
- `tohost` sampled nonzero at edge m: state, `status`, `done`, `result` and `core_rst`=1 all update at edge m. `disp_sel`=1 and `disp`=`result` are visible from that edge.
- `cyc` freezes at the value it held when the verdict was sampled. That value is the number of RUN cycles before the verdict edge.
- Loss of lock mid-RUN: `core_rst`=1 two cycles after `locked` falls (synchronizer) plus one edge.

## Test plan
- Reset, then `locked`=1: `core_rst` stays 1 until 2+1+16 edges after lock, `status` 00→01, `disp` counts 0,1,2….
- Drive `tohost`=1 at RUN cycle 500: `status`=10, `done`=1, `core_rst`=1, `disp`=1 with `disp_sel`=1. After DISP_PERIOD (set to 8) cycles, `disp`=500 with `disp_sel`=0, then back to 1.
- Drive `tohost`=0x0000_0007 at cycle 20: `status`=11, `result`=7, `disp` alternates 7 / 20.
- TIMEOUT_CYCLES=64 and `tohost` held 0: at RUN cycle 63, `status`=11 and `disp` alternates 0xFFFF_FFFF / 63. With `tohost`=1 arriving in the same cycle, `status`=10 instead.
- Drop `locked` mid-RUN: within 3 edges `core_rst`=1, `status`=00, `disp`=0. Re-lock repeats the HOLD sequence from `cyc`=0.
- Assert `RST`=0 asynchronously in PASS: all outputs take their reset values immediately, without waiting for a `CLK` edge.
